// File: rtl/uart_tx_scheduler_pkg.sv
// uart_tx_scheduler_pkg: state encoding and width defaults shared by the TX scheduler, FIFO and UART core.
package uart_tx_scheduler_pkg;

    localparam int DEF_DATA_SIZE = 8;
    localparam int INDEX_LENGTH  = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SEND  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

endpackage

// File: rtl/uart_tx_scheduler_gap_timer.sv
// uart_tx_scheduler_gap_timer: loadable down-counter that times the idle gap between characters.
module uart_tx_scheduler_gap_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;

    always_ff @(posedge clk_i) cnt_q <= rst_i ? '0 : cnt_d;

    assign zero_o = cnt_q == '0;

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: pops characters from the TX FIFO and feeds them to the UART serialiser,
// handling flush, enable gating, the inter-character gap and the TX-empty interrupt.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int DATA_SIZE  = DEF_DATA_SIZE,
    parameter int GAP_CYCLES = 0,
    parameter int GAP_WIDTH  = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 flush_i,
    input  logic                 fifo_load_i,
    input  logic [DATA_SIZE-1:0] fifo_data_i,
    output logic                 fifo_pull_o,
    output logic                 fifo_rst_o,
    input  logic                 uart_ready_i,
    output logic                 uart_start_o,
    output logic [DATA_SIZE-1:0] uart_data_o,
    input  logic                 uart_done_i,
    output logic                 tx_empty_irq_o,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] chars_sent_o
);

    state_e               state_q, state_d;
    logic [DATA_SIZE-1:0] data_q, data_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 pend_q, pend_d;
    logic                 flush_prev_q, pull_q, frst_q, irq_q, busy_q;
    logic                 fetch, go, done, gap_zero;

    // Fetching is also blocked during the FIFO soft-reset pulse so a stale load flag is never trusted.
    assign fetch = enable_i & fifo_load_i & ~flush_i & ~frst_q;
    assign go    = fetch & ~pend_q;
    assign done  = (state_q == ST_WAIT) & uart_done_i;

    generate
        if (GAP_CYCLES > 0) begin : g_gap
            uart_tx_scheduler_gap_timer #(
                .WIDTH(GAP_WIDTH)
            ) u_gap (
                .clk_i      (clk_i),
                .rst_i      (rst_i),
                .load_i     (done),
                .load_val_i (GAP_WIDTH'(GAP_CYCLES - 1)),
                .dec_i      (state_q == ST_GAP),
                .zero_o     (gap_zero)
            );
        end else begin : g_nogap
            assign gap_zero = 1'b1;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE:  state_d = go ? ST_FETCH : ST_IDLE;
            ST_FETCH: begin
                data_d  = fifo_data_i;
                state_d = flush_i ? ST_IDLE : ST_SEND;
            end
            ST_SEND:  state_d = flush_i ? ST_IDLE : uart_ready_i ? ST_WAIT : ST_SEND;
            ST_WAIT:  if (uart_done_i) begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (GAP_CYCLES > 0) ? ST_GAP : go ? ST_FETCH : ST_IDLE;
            end
            ST_GAP:   if (gap_zero) state_d = go ? ST_FETCH : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        pend_d = (state_d != ST_IDLE) & (pend_q | flush_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            data_q       <= '0;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            flush_prev_q <= 1'b0;
            pull_q       <= 1'b0;
            frst_q       <= 1'b0;
            irq_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            flush_prev_q <= flush_i;
            pull_q       <= state_d == ST_FETCH;
            frst_q       <= flush_i & ~flush_prev_q;
            irq_q        <= done & ~fifo_load_i & ~pend_q & ~flush_i;
            busy_q       <= state_d != ST_IDLE;
        end
    end

    assign fifo_pull_o    = pull_q;
    assign fifo_rst_o     = frst_q;
    assign uart_start_o   = (state_q == ST_SEND) & uart_ready_i & ~flush_i;
    assign uart_data_o    = data_q;
    assign tx_empty_irq_o = irq_q;
    assign busy_o         = busy_q;
    assign chars_sent_o   = cnt_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed bench for the TX scheduler with a gapless and a 3-cycle-gap instance.
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst_i, enable_i, flush_i, uart_ready_i, uart_done_i;
    logic        fifo_load_i, g_load;
    logic [7:0]  fifo_data_i, g_data;
    logic        fifo_pull_o, fifo_rst_o, uart_start_o, tx_empty_irq_o, busy_o;
    logic [7:0]  uart_data_o;
    logic [15:0] chars_sent_o;
    logic        g_pull, g_frst, g_start, g_irq, g_busy;
    logic [7:0]  g_udata;
    logic [15:0] g_chars;

    logic rs = 1'b0, en = 1'b0, rdy = 1'b0, dn = 1'b0, fl = 1'b0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic pop0 = 1'b0, pop1 = 1'b0;
    int ncmp = 0, nfail = 0;
    int cycle = 0;
    int npull, nstart, nirq, nrst, last_start, last_irq;
    int g_npull, g_nirq, g_last_start;
    int dcyc[$];
    int g_pcyc[$];
    logic [7:0] sdata[$];
    logic [7:0] g_sdata[$];

    always #5 clk = ~clk;

    uart_tx_scheduler dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .flush_i(flush_i),
        .fifo_load_i(fifo_load_i), .fifo_data_i(fifo_data_i), .fifo_pull_o(fifo_pull_o),
        .fifo_rst_o(fifo_rst_o), .uart_ready_i(uart_ready_i), .uart_start_o(uart_start_o),
        .uart_data_o(uart_data_o), .uart_done_i(uart_done_i), .tx_empty_irq_o(tx_empty_irq_o),
        .busy_o(busy_o), .chars_sent_o(chars_sent_o)
    );

    uart_tx_scheduler #(.GAP_CYCLES(3)) dut_gap (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .flush_i(flush_i),
        .fifo_load_i(g_load), .fifo_data_i(g_data), .fifo_pull_o(g_pull),
        .fifo_rst_o(g_frst), .uart_ready_i(uart_ready_i), .uart_start_o(g_start),
        .uart_data_o(g_udata), .uart_done_i(uart_done_i), .tx_empty_irq_o(g_irq),
        .busy_o(g_busy), .chars_sent_o(g_chars)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_tally();
        npull = 0; nstart = 0; nirq = 0; nrst = 0; last_start = -1000; last_irq = -1000;
        g_npull = 0; g_nirq = 0; g_last_start = -1000;
        dcyc.delete(); g_pcyc.delete(); sdata.delete(); g_sdata.delete();
    endtask

    // One clock cycle: FIFO model upkeep and input drive at the falling edge, observation 1 time unit later.
    task automatic cyc();
        @(negedge clk);
        if (pop0 && q0.size() > 0) void'(q0.pop_front());
        if (pop1 && q1.size() > 0) void'(q1.pop_front());
        pop0 = fifo_pull_o;
        pop1 = g_pull;
        if (fifo_rst_o) begin q0.delete(); pop0 = 1'b0; end
        if (g_frst) begin q1.delete(); pop1 = 1'b0; end
        rst_i = rs; enable_i = en; uart_ready_i = rdy; uart_done_i = dn; flush_i = fl;
        dn = 1'b0;
        fifo_load_i = q0.size() != 0;
        fifo_data_i = fifo_load_i ? q0[0] : 8'h00;
        g_load = q1.size() != 0;
        g_data = g_load ? q1[0] : 8'h00;
        #1;
        cycle++;
        if (uart_done_i) dcyc.push_back(cycle);
        if (fifo_pull_o) npull++;
        if (uart_start_o) begin nstart++; last_start = cycle; sdata.push_back(uart_data_o); end
        if (tx_empty_irq_o) begin nirq++; last_irq = cycle; end
        if (fifo_rst_o) nrst++;
        if (g_pull) begin g_npull++; g_pcyc.push_back(cycle); end
        if (g_start) begin g_last_start = cycle; g_sdata.push_back(g_udata); end
        if (g_irq) g_nirq++;
    endtask

    task automatic do_reset();
        rs = 1'b1; en = 1'b0; rdy = 1'b0; fl = 1'b0; dn = 1'b0;
        q0.delete(); q1.delete(); pop0 = 1'b0; pop1 = 1'b0;
        cyc();
        rs = 1'b0;
        cyc();
        clear_tally();
    endtask

    initial begin
        clear_tally();
        do_reset();
        chk("rst_pull", fifo_pull_o, 0);
        chk("rst_start", uart_start_o, 0);
        chk("rst_irq", tx_empty_irq_o, 0);
        chk("rst_frst", fifo_rst_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_chars", chars_sent_o, 0);
        chk("rst_data", uart_data_o, 0);

        q0.push_back(8'hA5); en = 1'b1; rdy = 1'b1;
        cyc();
        chk("s_pull_N", fifo_pull_o, 0);
        cyc();
        chk("s_pull_N1", fifo_pull_o, 1);
        chk("s_start_N1", uart_start_o, 0);
        chk("s_busy_N1", busy_o, 1);
        cyc();
        chk("s_start_N2", uart_start_o, 1);
        chk("s_data_N2", uart_data_o, 8'hA5);
        chk("s_pull_N2", fifo_pull_o, 0);
        cyc(); cyc();
        dn = 1'b1; cyc();
        chk("s_irq_done", tx_empty_irq_o, 0);
        cyc();
        chk("s_chars", chars_sent_o, 1);
        chk("s_irq", tx_empty_irq_o, 1);
        chk("s_busy_end", busy_o, 0);
        cyc();
        chk("s_irq_once", tx_empty_irq_o, 0);

        do_reset();
        for (int i = 1; i <= 4; i++) q0.push_back(8'(i));
        en = 1'b1; rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (cycle + 1 == last_start + 8) dn = 1'b1;
            cyc();
            if (uart_start_o && dcyc.size() > 0) chk("b_start_after_done", cycle - dcyc[$], 2);
        end
        chk("b_pulls", npull, 4);
        chk("b_starts", nstart, 4);
        for (int i = 0; i < 4 && i < sdata.size(); i++) chk("b_order", sdata[i], i + 1);
        chk("b_irqs", nirq, 1);
        chk("b_irq_when", last_irq, dcyc.size() == 4 ? dcyc[3] + 1 : -1);
        chk("b_chars", chars_sent_o, 4);

        do_reset();
        q1.push_back(8'h11); q1.push_back(8'h22);
        en = 1'b1; rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (cycle + 1 == g_last_start + 8) dn = 1'b1;
            cyc();
        end
        chk("g_pulls", g_npull, 2);
        chk("g_pull_gap", (g_pcyc.size() == 2 && dcyc.size() > 0) ? g_pcyc[1] - dcyc[0] : -1, 4);
        chk("g_data2", g_sdata.size() == 2 ? g_sdata[1] : 8'hxx, 8'h22);
        chk("g_chars", g_chars, 2);
        chk("g_irqs", g_nirq, 1);
        chk("g_main_idle", npull, 0);

        do_reset();
        q0.push_back(8'h5A); en = 1'b1; rdy = 1'b0;
        for (int i = 0; i < 22; i++) cyc();
        chk("r_no_start", nstart, 0);
        chk("r_busy", busy_o, 1);
        rdy = 1'b1;
        cyc();
        chk("r_start", uart_start_o, 1);
        chk("r_data", uart_data_o, 8'h5A);
        cyc(); cyc(); cyc();
        chk("r_starts", nstart, 1);
        chk("r_pulls", npull, 1);

        do_reset();
        q0.push_back(8'h31); q0.push_back(8'h32); q0.push_back(8'h33);
        en = 1'b1; rdy = 1'b1;
        cyc(); cyc(); cyc(); cyc(); cyc();
        fl = 1'b1; cyc();
        fl = 1'b0; cyc();
        chk("f_rst_pulse", fifo_rst_o, 1);
        dn = 1'b1; cyc();
        cyc();
        chk("f_chars", chars_sent_o, 1);
        chk("f_busy", busy_o, 0);
        for (int i = 0; i < 10; i++) cyc();
        chk("f_rsts", nrst, 1);
        chk("f_irqs", nirq, 0);
        chk("f_pulls", npull, 1);

        do_reset();
        q0.push_back(8'h66); en = 1'b1; rdy = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        dn = 1'b1; cyc();
        cyc();
        chk("m_chars_pre", chars_sent_o, 1);
        q0.push_back(8'h77);
        cyc(); cyc(); cyc(); cyc();
        chk("m_busy_pre", busy_o, 1);
        rs = 1'b1; cyc();
        rs = 1'b0; cyc();
        chk("m_chars", chars_sent_o, 0);
        chk("m_busy", busy_o, 0);
        chk("m_data", uart_data_o, 0);
        chk("m_start", uart_start_o, 0);
        dn = 1'b1; cyc();
        cyc();
        chk("m_done_ignored", chars_sent_o, 0);
        chk("m_irq", tx_empty_irq_o, 0);

        do_reset();
        q0.push_back(8'h44); en = 1'b0; rdy = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        chk("e_no_pull", npull, 0);
        chk("e_busy", busy_o, 0);
        en = 1'b1;
        cyc(); cyc();
        chk("e_pull", fifo_pull_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Sequences the transmit path: pops characters from the TX internal FIFO and hands them one at a time to the UART bit-serialiser.
- Handles flush requests, enable gating and the optional inter-character idle gap.
- Raises a transmit-empty interrupt pulse.
- Sits between the TX FIFO (load flag, head data, pull, soft reset) and the UART transmitter (ready/start/done handshake).

Parameters:
- DATA_SIZE, 8, character width in bits; matches the FIFO data width.
- GAP_CYCLES, 0, idle clock cycles inserted after each character's done before the next fetch.
- GAP_WIDTH, 8, width of the gap counter; GAP_CYCLES must be < 2^GAP_WIDTH.
- CNT_WIDTH, 16, width of the sent-character counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- enable_i  in  1  TX enable from the control register.
- flush_i  in  1  request to discard TX FIFO contents.
- fifo_load_i  in  1  FIFO head entry is valid (FIFO load flag).
- fifo_data_i  in  DATA_SIZE  FIFO head data (combinational from the FIFO).
- fifo_pull_o  out  1  one-cycle pull strobe to the FIFO.
- fifo_rst_o  out  1  one-cycle soft-reset strobe to the FIFO.
- uart_ready_i  in  1  serialiser idle, can accept a character.
- uart_start_o  out  1  start strobe to the serialiser.
- uart_data_o  out  DATA_SIZE  character presented to the serialiser.
- uart_done_i  in  1  one-cycle pulse at end of stop bit.
- tx_empty_irq_o  out  1  one-cycle pulse: last character finished and FIFO empty.
- busy_o  out  1  scheduler not IDLE.
- chars_sent_o  out  CNT_WIDTH  count of completed characters.

Behaviour:
- One clock (clk_i). rst_i is synchronous, active-high and overrides everything.
  - On reset: state=IDLE; all outputs 0; data register, gap counter, chars_sent_o and flush-pending flag all cleared.
- Fetch condition F = enable_i & fifo_load_i & ~flush_i.
- FSM states: IDLE, FETCH, SEND, WAIT, GAP.
- IDLE:
  - F -> FETCH.
  - Otherwise stay.
- FETCH (exactly 1 cycle):
  - fifo_pull_o=1.
  - Data register <= fifo_data_i.
  - Next state SEND.
- SEND:
  - uart_data_o = data register.
  - uart_start_o = uart_ready_i, combinational.
  - When uart_ready_i=1, go to WAIT; otherwise hold in SEND indefinitely.
- WAIT:
  - On uart_done_i: chars_sent_o++ (wraps modulo 2^CNT_WIDTH).
  - Then, if GAP_CYCLES>0 -> GAP with counter=GAP_CYCLES-1.
  - Else: F -> FETCH; otherwise -> IDLE.
- GAP:
  - Counter decrements each cycle.
  - At 0: F -> FETCH, else IDLE.
- Latency: fifo_load_i rising in IDLE at cycle N -> fifo_pull_o at N+1 -> uart_start_o at N+2 (if ready).
- Back-to-back with GAP_CYCLES=0: done at cycle M -> pull at M+1 -> start at M+2.
- tx_empty_irq_o:
  - Registered pulse, one cycle after the uart_done_i cycle.
  - Fires when fifo_load_i=0 in the done cycle and no flush is pending.
  - Never fires while enable_i=0 leaves data in the FIFO.
- Flush:
  - fifo_rst_o is a registered copy of the flush_i rising edge: one pulse per request, one cycle after the edge.
  - flush_i in FETCH or SEND: latched character dropped, no start issued, -> IDLE.
  - flush_i in WAIT or GAP: current character completes and is counted, no irq, then -> IDLE. A flush-pending flag carries the request until the character completes.
  - No FETCH while flush_i=1 or while fifo_rst_o=1.
- enable_i deassert:
  - Character in SEND/WAIT completes.
  - No further fetch; FIFO contents retained.
- Ignored inputs:
  - uart_done_i outside WAIT is ignored.
  - fifo_load_i is sampled only in decision cycles.
- busy_o = (state != IDLE), registered from state.
- fifo_pull_o is asserted only when fifo_load_i was 1 in the transition cycle, so the scheduler never pulls an empty FIFO.

Decomposition:
- Shared package/include (uart_defines):
  - FSM state encoding localparams (IDLE=0, FETCH=1, SEND=2, WAIT=3, GAP=4, 3-bit).
  - Default DATA_SIZE and INDEX_LENGTH constants, shared with the FIFO and UART core.
- Sub-module uart_gap_timer (load/decrement/zero-flag, GAP_WIDTH wide) is natural but optional.
  - When GAP_CYCLES=0 it must be removed by generate.

Test Plan:
- Single char: push 0xA5, enable_i=1, uart_ready_i=1 -> pull at N+1; start with uart_data_o=0xA5 at N+2; done pulse -> chars_sent_o=1, tx_empty_irq_o one pulse next cycle.
- Burst 4 chars (0x01..0x04), GAP_CYCLES=0, done every 10 cycles -> exactly 4 pulls and 4 starts in order; each start 2 cycles after the prior done; one irq after the 4th; chars_sent_o=4.
- GAP_CYCLES=3, 2 chars -> second pull exactly 4 cycles after first done (3 gap cycles + decision).
- uart_ready_i held 0 for 20 cycles in SEND -> uart_start_o=0 throughout; start on the first ready cycle; no extra pull.
- Flush during WAIT with 3 chars queued -> fifo_rst_o single pulse; current char done and counted; no irq; FSM IDLE; no further pulls.
- rst_i asserted mid-WAIT -> next cycle all outputs 0, chars_sent_o=0, state IDLE; later uart_done_i ignored.
